bit_count_scheduler: RTL and testbench
======================================

# bit_count_scheduler

Sequences a single shared ones-counting engine (shift register plus result counter) between two requesters using round-robin arbitration and a level-request / done-pulse handshake. Each granted operand is loaded, shifted out LSB-first, and counted; the count is returned to the winning requester. It sits between operand sources (switch inputs, a second on-board source) and the result consumer (hex display driver, LED status). Control FSM and the shared datapath are owned by this block.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- CW, $clog2(WIDTH+1), derived result width; not overridden
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; dominates every other input
- req  input  2  level request per requester; held high until matching done bit seen
- in0  input  WIDTH  operand of requester 0; sampled only on its grant edge
- in1  input  WIDTH  operand of requester 1; sampled only on its grant edge
- ready  output  1  high in S_IDLE; engine free
- grant  output  2  one-hot current owner during S_COUNT and S_DONE, else 0
- done  output  2  one-cycle pulse to owner, high exactly in S_DONE
- result  output  CW  ones count of last completed operation; stable until next S_DONE

## Operation
- Internal state: A (WIDTH), cnt (CW), shift counter sc (CW), owner (1), last (1), state.
- S_IDLE: ready=1. If req≠0: winner = the only requester if one, else requester ≠ last. A←in[winner], cnt←0, sc←0, owner←winner, → S_COUNT. If req=0: stay.
- S_COUNT: per edge, termination test first: if terminate → result←cnt, → S_DONE; else cnt←cnt+A[0], A←A>>1, sc←sc+1.
- Terminate condition: sc==WIDTH (default) or A==0 (see Configuration).
- S_DONE: done[owner]=1, grant still = owner; last←owner; → S_IDLE.
- req deassertion during S_COUNT/S_DONE ignored; operation completes, done still pulses.
- req still high in S_IDLE after done is a new request (re-arbitrated, operand resampled).
- Changes on in0/in1 after grant edge have no effect.
- cnt never overflows: max value WIDTH fits in CW bits.
- Reset (any state, incl. mid-count): state=S_IDLE, A=0, cnt=0, sc=0, result=0, owner=0, last=1, done=0, grant=0, ready=1 on next cycle. In-flight operation discarded, no done pulse.
- After reset, first tie goes to requester 0.

## Timing
- Grant edge = edge at which S_IDLE samples req≠0 (edge 0).
- Default: done rises WIDTH+1 edges after edge 0 (9 for WIDTH=8), independent of operand.
- Early-exit build: done rises p+2 edges after edge 0, p = index of highest set bit; operand 0 → 1 edge.
- result updates on the same edge done rises; valid in the done cycle and after.
- done high exactly one cycle; S_IDLE entered the next edge; new grant possible on the edge after that (min one ready cycle between operations).
- Back-to-back with both req held: grants alternate 0,1,0,1.

## Configuration
- BITCOUNT_EARLY_EXIT_EN defined: terminate when A==0; sc unused; variable latency as above.
- Not defined: terminate when sc==WIDTH; fixed latency WIDTH+1 for all operands.
- Result values identical in both builds.

## Test plan
- Reset, req=01, in0=8'hFF, held → grant=01 after edge 0; default: done=01 at edge 9, result=8.
- req=11 from reset with in0=8'h0F, in1=8'hA5, both held → first done=01 result=4, next done=10 result=4, then 01 again (alternation).
- Early-exit build: in0=8'h00 → done at edge 1, result=0; in0=8'h80 → done at edge 9, result=1; in0=8'h03 → done at edge 3, result=2.
- Grant req=10 in1=8'h55, change in1 to 8'hFF and drop req mid-count → done=10 still pulses, result=4.
- Assert reset at edge 4 of a count → next cycle ready=1, grant=0, result=0, no done pulse; subsequent req=11 grants requester 0.
- Hold req=01 continuously → done pulses exactly one cycle per operation with ≥1 ready cycle between, result stable between pulses.

Source files
------------

// File: rtl/bit_count_scheduler.sv
// bit_count_scheduler
// Shares one ones-counting engine (shift register + counter) between two
// requesters with round-robin arbitration. Each requester holds req high
// until it sees its done bit; the count is returned on result.
//
// Handshake: req[i] is a level request. The engine samples req only in
// S_IDLE (ready=1); the winning operand is captured on that grant edge.
// grant[i] marks the owner for the whole operation and done[i] pulses for
// exactly one cycle when result becomes valid. Dropping req after the grant
// edge does not cancel the operation.
//
// Optional build macro: BITCOUNT_EARLY_EXIT_EN
//   defined     -> counting stops once the shift register is empty
//                  (variable latency, shift counter unused)
//   not defined -> counting always runs WIDTH shifts (fixed latency)
// The result value is the same in both builds.
module bit_count_scheduler #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             ready,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [CW-1:0]    result,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    sc;
    logic             owner;
    logic             last;
    logic             winner;
    logic             terminate;

    assign dbg_state = state;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

`ifdef BITCOUNT_EARLY_EXIT_EN
    // Nothing left to count once the shift register has drained.
    assign terminate = (a == '0);
`else
    // Always shift the full operand width for a fixed latency.
    assign terminate = (sc == CW'(WIDTH));
`endif

    // Control FSM and shared datapath, with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a      <= '0;
            cnt    <= '0;
            sc     <= '0;
            result <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
            done   <= 2'b00;
            grant  <= 2'b00;
            ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        a     <= winner ? in1 : in0;
                        cnt   <= '0;
                        sc    <= '0;
                        owner <= winner;
                        grant <= winner ? 2'b10 : 2'b01;
                        ready <= 1'b0;
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (terminate) begin
                        result <= cnt;
                        done   <= grant;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(a[0]);
                        a   <= a >> 1;
                        sc  <= sc + 1'b1;
                    end
                end
                S_DONE: begin
                    last  <= owner;
                    done  <= 2'b00;
                    grant <= 2'b00;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_count_scheduler.sv
// Bench for bit_count_scheduler: directed scenarios plus randomized
// operations, checked against a reference model of arbitration, popcount
// and latency.
module tb_bit_count_scheduler;

    localparam int WIDTH = 8;
    localparam int CW = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             ready;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic [CW-1:0]    result;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] exp_q[$];
    logic          last_m;

    bit_count_scheduler #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .ready     (ready),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: number of set bits
    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // reference: edges from grant edge to done edge
    function automatic int latency(input logic [WIDTH-1:0] v);
`ifdef BITCOUNT_EARLY_EXIT_EN
        int p = -1;
        for (int i = 0; i < WIDTH; i++) if (v[i]) p = i;
        return (p < 0) ? 1 : p + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        reset  = 1'b0;
        last_m = 1'b1;
        exp_q.delete();
    endtask

    // One operation: drive req/operands in a ready cycle, then follow it to
    // done. mangle=1 changes operands and drops req after the grant edge.
    task automatic do_op(input logic [1:0] r, input logic [WIDTH-1:0] a0,
                         input logic [WIDTH-1:0] a1, input bit mangle);
        logic          w;
        logic [WIDTH-1:0] opnd;
        logic [CW-1:0] exp_res;
        int            lat;
        int            e;
        check("pre_ready", 32'(ready), 32'd1);
        req = r;
        in0 = a0;
        in1 = a1;
        w = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~last_m;
        opnd = w ? a1 : a0;
        exp_q.push_back(CW'(popcount(opnd)));
        lat = latency(opnd);
        @(posedge clk);
        #1;
        check("grant", 32'(grant), w ? 32'd2 : 32'd1);
        check("busy_ready", 32'(ready), 32'd0);
        if (mangle) begin
            in0 = ~a0;
            in1 = ~a1;
            req = 2'b00;
        end
        e = 0;
        while (done == 2'b00 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        check("latency", 32'(e), 32'(lat));
        check("done", 32'(done), w ? 32'd2 : 32'd1);
        check("done_grant", 32'(grant), w ? 32'd2 : 32'd1);
        exp_res = exp_q.pop_front();
        check("result", 32'(result), 32'(exp_res));
        last_m = w;
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_grant", 32'(grant), 32'd0);
        check("result_hold", 32'(result), 32'(exp_res));
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        in0   = '0;
        in1   = '0;
        last_m = 1'b1;
        do_reset();

        // single requester, all ones
        do_op(2'b01, 8'hFF, 8'h00, 1'b0);
        req = 2'b00;

        // tie from reset: alternation 0,1,0
        do_reset();
        do_op(2'b11, 8'h0F, 8'hA5, 1'b0);
        do_op(2'b11, 8'h0F, 8'hA5, 1'b0);
        do_op(2'b11, 8'h0F, 8'hA5, 1'b0);

        // latency corner operands
        do_op(2'b01, 8'h00, 8'h00, 1'b0);
        do_op(2'b01, 8'h80, 8'h00, 1'b0);
        do_op(2'b01, 8'h03, 8'h00, 1'b0);

        // operand change and req drop mid-count
        do_op(2'b10, 8'h00, 8'h55, 1'b1);

        // reset in the middle of a count
        req = 2'b01;
        in0 = 8'hFF;
        @(posedge clk);
        repeat (4) @(posedge clk);
        reset = 1'b1;
        req   = 2'b00;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset  = 1'b0;
        last_m = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("midrst_nodone", 32'(done), 32'd0);
        end
        do_op(2'b11, 8'h12, 8'h34, 1'b0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            do_op(r, WIDTH'($urandom), WIDTH'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
